div8x4_seq: RTL and testbench

//  Iterative restoring unsigned divider: inverse of the 4x4 multiplier.

---
 rtl/div8x4_seq_if.sv | 25 ++
 rtl/div8x4_seq.sv | 116 +++++++++++
 tb/tb_div8x4_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div8x4_seq_if.sv
// Start/busy/done handshake and operand/result bus for the iterative divider.
// The master issues requests; the slave is the divider itself.
interface div8x4_seq_if #(
    parameter int N = 8,
    parameter int D = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [D-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [D-1:0] remainder;
    logic         div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div8x4_seq.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Fixed latency of N RUN cycles regardless of operands, including divide-by-zero.
module div8x4_seq #(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    div8x4_seq_if.slave bus
);
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [N-1:0]  dvd_q, dvd_d;
    logic [D-1:0]  dsr_q, dsr_d;
    logic [D-1:0]  pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [D-1:0]  remainder_q, remainder_d;
    logic          div_zero_q, div_zero_d;

    logic [D:0]    trial;
    logic [D-1:0]  sub_lo;
    logic          borrow;
    logic [D-1:0]  pr_next;
    logic [N-1:0]  dvd_next;

    // Trial value is D+1 bits; when it is >= divisor the difference is < divisor,
    // so the low D bits of the subtraction are the exact new partial remainder.
    always_comb begin
        trial    = {pr_q, dvd_q[N-1]};
        borrow   = (trial < {1'b0, dsr_q});
        sub_lo   = trial[D-1:0] - dsr_q;
        pr_next  = borrow ? trial[D-1:0] : sub_lo;
        dvd_next = {dvd_q[N-2:0], ~borrow};
    end

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        pr_d        = pr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dsr_d   = bus.divisor;
                    pr_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                pr_d  = pr_next;
                dvd_d = dvd_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    // Divide-by-zero still runs the full schedule, then reports a saturated quotient.
                    if (dsr_q == '0) begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        div_zero_d  = 1'b1;
                    end else begin
                        quotient_d  = dvd_next;
                        remainder_d = pr_next;
                        div_zero_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            pr_q        <= pr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.done      = (state_q == DONE);
        bus.quotient  = quotient_q;
        bus.remainder = remainder_q;
        bus.div_zero  = div_zero_q;
    end
endmodule

// File: tb/tb_div8x4_seq.sv
// Directed plus exhaustive bench for div8x4_seq; a negedge monitor pops the
// scoreboard on every done pulse and checks results, invariants and output hold.
module tb_div8x4_seq;
    logic clk;
    logic rst_n;

    div8x4_seq_if #(.N(8), .D(4)) bus ();

    div8x4_seq #(.N(8), .D(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_done   = 0;

    logic [7:0] hold_q = '0;
    logic [3:0] hold_r = '0;
    logic       hold_z = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.q  = (b == 0) ? 8'hFF : 8'(a / b);
        e.r  = (b == 0) ? 4'd0  : 4'(a % b);
        e.dz = (b == 0);
        sb.push_back(e);
        n_pushed++;
    endtask

    // Scoreboard consumer and output-hold checker.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_q = '0;
            hold_r = '0;
            hold_z = 1'b0;
        end else begin
            check("busy_done_excl", 32'(bus.busy & bus.done), 0);
            if (bus.done === 1'b1) begin
                n_done++;
                check("done_has_request", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", 32'(bus.quotient), 32'(e.q));
                    check("remainder", 32'(bus.remainder), 32'(e.r));
                    check("div_zero", 32'(bus.div_zero), 32'(e.dz));
                    if (e.b != 0) begin
                        check("inv_qb_plus_r", 32'(bus.quotient) * 32'(e.b) + 32'(bus.remainder), 32'(e.a));
                        check("inv_r_lt_b", 32'(bus.remainder < e.b), 1);
                    end
                end
                hold_q = bus.quotient;
                hold_r = bus.remainder;
                hold_z = bus.div_zero;
            end else begin
                check("hold_quotient", 32'(bus.quotient), 32'(hold_q));
                check("hold_remainder", 32'(bus.remainder), 32'(hold_r));
                check("hold_div_zero", 32'(bus.div_zero), 32'(hold_z));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (bus.busy !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle", 32'(bus.busy), 0);
    endtask

    // Returns #1 after the accepting edge.
    task automatic accept(input logic [7:0] a, input logic [3:0] b);
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        push_exp(a, b);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
    endtask

    // Counts negedges until done is seen (bounded).
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.done !== 1'b1 && cycles < 30);
        check(tag, 32'(bus.done), 1);
    endtask

    initial begin
        int c;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_quotient", 32'(bus.quotient), 0);
        check("rst_remainder", 32'(bus.remainder), 0);
        check("rst_div_zero", 32'(bus.div_zero), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 200/7 with exact latency, plus ignored start pulse while busy
        accept(8'd200, 4'd7);
        for (int k = 0; k < 8; k++) begin
            check("lat_busy", 32'(bus.busy), 1);
            check("lat_no_done", 32'(bus.done), 0);
            if (k == 2) begin
                bus.start = 1'b1; bus.dividend = 8'd13; bus.divisor = 4'd2;
            end
            if (k == 3) bus.start = 1'b0;
            @(posedge clk);
            #1;
        end
        check("lat_done", 32'(bus.done), 1);
        check("lat_busy_low", 32'(bus.busy), 0);
        check("lat_q_200_7", 32'(bus.quotient), 28);
        check("lat_r_200_7", 32'(bus.remainder), 4);
        @(posedge clk);
        #1;
        check("done_single", 32'(bus.done), 0);

        accept(8'd255, 4'd1);
        accept(8'd5, 4'd9);
        accept(8'd0, 4'd15);
        accept(8'd100, 4'd0);
        accept(8'd100, 4'd3);
        wait_idle();

        // Start held high: accepted in each DONE cycle, one done every 9 cycles
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd77; bus.divisor = 4'd4;
        push_exp(8'd77, 4'd4);
        wait_done("b2b_first_done", c);
        for (int i = 0; i < 4; i++) begin
            bus.dividend = 8'($urandom); bus.divisor = 4'($urandom_range(0, 15));
            push_exp(bus.dividend, bus.divisor);
            wait_done("b2b_done", c);
            check("b2b_spacing", 32'(c), 9);
        end
        bus.start = 1'b0;
        wait_idle();

        // Reset in RUN cycle 4 aborts the op without a done
        accept(8'd50, 4'd6);
        void'(sb.pop_back());
        n_pushed--;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_quotient", 32'(bus.quotient), 0);
        check("abort_remainder", 32'(bus.remainder), 0);
        check("abort_div_zero", 32'(bus.div_zero), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        check("abort_no_done", 32'(n_done), 32'(n_pushed));
        #1;
        accept(8'd123, 4'd5);
        wait_done("post_reset_done", c);
        check("post_reset_latency", 32'(c), 9);

        // Exhaustive sweep, back to back through the DONE state
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                accept(8'(a), 4'(b));
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 0);
        check("done_per_start", 32'(n_done), 32'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
